// File: rtl/mem_access_wb_pkg.sv
// Shared encodings for the MEM stage: funct3 sizes, write-back sources, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_wb_pkg;

    // funct3 size/sign encodings (loads and stores share the low codes)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // write-back source select
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;
    localparam logic [1:0] WB_PCIMM = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] off);
        case (funct)
            LH, LHU: return off[0];
            LW:      return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_wb_if.sv
// Data-memory request/ready bus between the MEM stage and the data memory.
// Latency: n/a (signal bundle only).
// Backpressure: memory holds ready low to insert wait states.
interface mem_access_wb_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load extract/extend.
// Latency: purely combinational.
// Backpressure: none.
module mem_lane_align
    import mem_access_wb_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    // addressed byte/halfword moved down to bit 0
    assign ld_shift = rdata >> {off, 3'b000};

    // store: replicate the narrow value on every lane, enable only the addressed ones
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (funct)
            SB: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{st_data[7:0]}};
            end
            SH: begin
                st_be    = 4'b0011 << off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // load: extract the addressed item and sign/zero extend it
    always_comb begin
        ld_data = rdata;
        case (funct)
            LB:      ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            LBU:     ld_data = {24'h0, ld_shift[7:0]};
            LH:      ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            LHU:     ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage: data-memory access, load/store lane alignment, write-back select, MEM/WB register.
// Latency: 1 cycle from EX/MEM to MEM/WB when memory answers in the request cycle.
// Backpressure: mem_stall freezes upstream while memory is not ready; aborts after TIMEOUT_CYC waits.
module mem_access_wb
    import mem_access_wb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_writeM,
    input  logic [1:0]      reg_srcM,
    input  logic            mem_readM,
    input  logic            mem_writeM,
    input  logic [31:0]     rlt_outM,
    input  logic [31:0]     B_out,
    input  logic [4:0]      rd_outM,
    input  logic [2:0]      functM,
    input  logic [31:0]     pc_4M,
    input  logic [31:0]     pc_immM,
    mem_access_wb_if.master dmem,
    output logic            mem_stall,
    output logic            reg_writeW,
    output logic [4:0]      rd_outW,
    output logic [31:0]     wb_dataW,
    output logic            misalign_err,
    output logic            bus_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       hold_addr, hold_wdata;
    logic [3:0]        hold_be;
    logic              hold_we;
    logic              access, misaligned, abort, latch_hold;
    logic              req_c, we_c;
    logic [31:0]       addr_c, wdata_c;
    logic [3:0]        be_c;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata, ld_data, wb_mux;

    assign access     = mem_readM | mem_writeM;
    assign misaligned = access & is_misaligned(functM, rlt_outM[1:0]);

    // EX/MEM stays frozen while stalled, so the live address offset is valid for load extract
    mem_lane_align u_lane_align (
        .funct    (functM),
        .off      (rlt_outM[1:0]),
        .st_data  (B_out),
        .rdata    (dmem.rdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_data  (ld_data)
    );

    // next state, wait counter, bus drive and stall
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        abort      = 1'b0;
        latch_hold = 1'b0;
        mem_stall  = 1'b0;
        req_c      = 1'b0;
        we_c       = mem_writeM;
        addr_c     = {rlt_outM[31:2], 2'b00};
        wdata_c    = st_wdata;
        be_c       = st_be;
        case (state)
            IDLE: begin
                req_c = access & ~misaligned;
                if (req_c && !dmem.ready) begin
                    latch_hold = 1'b1;
                    mem_stall  = 1'b1;
                    state_nxt  = WAIT;
                    cnt_nxt    = CNT_W'(1);
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                we_c    = hold_we;
                addr_c  = hold_addr;
                wdata_c = hold_wdata;
                be_c    = hold_be;
                if (dmem.ready) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    // give up: release the pipe and retire without a register write
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // reset drops an in-flight request immediately
        if (rst) begin
            req_c     = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign dmem.req   = req_c;
    assign dmem.we    = we_c;
    assign dmem.addr  = addr_c;
    assign dmem.wdata = wdata_c;
    assign dmem.be    = be_c;

    // FSM state and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // capture the request when it first has to wait so it is replayed unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_we    <= 1'b0;
        end else if (latch_hold) begin
            hold_addr  <= addr_c;
            hold_wdata <= wdata_c;
            hold_be    <= be_c;
            hold_we    <= we_c;
        end
    end

    // write-back source select
    always_comb begin
        case (reg_srcM)
            WB_ALU:   wb_mux = rlt_outM;
            WB_MEM:   wb_mux = ld_data;
            WB_PC4:   wb_mux = pc_4M;
            WB_PCIMM: wb_mux = pc_immM;
            default:  wb_mux = rlt_outM;
        endcase
    end

    // MEM/WB register: bubble while stalled, retire otherwise; error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_writeW   <= 1'b0;
            rd_outW      <= '0;
            wb_dataW     <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= misaligned;
            bus_err      <= abort;
            if (mem_stall) begin
                reg_writeW <= 1'b0;
            end else begin
                reg_writeW <= reg_writeM & ~misaligned & ~abort & (rd_outM != 5'd0);
                rd_outW    <= rd_outM;
                wb_dataW   <= wb_mux;
            end
        end
    end

endmodule
